regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_wb_arbiter_pkg                                      |
// | Brief  : Shared common types and constants for register-file         |
// |          writeback and other shared-resource controllers.            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package regfile_wb_arbiter_pkg;

  // Number of writeback requesters contending for the register-file port.
  localparam int WB_REQ_PORTS = 3;

  // Architectural register address and datapath word.
  typedef logic [4:0]  creg_addr_t;
  typedef logic [63:0] u64;

  // Saturation ceiling of 32-bit event counters.
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Saturating increment used by the event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_arbiter                                                  |
// | Brief  : Combinational round-robin arbiter. Search starts at ptr_i   |
// |          and walks upward modulo N; first set request wins.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk the requests from the pointer position, wrapping at N-1.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = ptr_i;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
      if (idx == PW'(N - 1)) begin
        idx = '0;
      end else begin
        idx = idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_wb_arbiter                                          |
// | Brief  : Round-robin arbitration of writeback requesters onto a      |
// |          single register-file write port, with a saturating         |
// |          contention counter.                                         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_REQ_PORTS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  creg_addr_t         req_addr_i [NUM_REQ],
  input  u64                 req_data_i [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready_o,
  output creg_addr_t         wa_o,
  output logic               wvalid_o,
  output u64                 wd_o,
  output logic [31:0]        contention_cnt_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wvalid_q, wvalid_d;
  creg_addr_t       wa_q;
  u64               wd_q;
  logic [31:0]      contention_cnt_q, contention_cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] ready;
  logic               any_gnt;
  logic [PTR_W-1:0]   gnt_idx;
  creg_addr_t         sel_addr;
  u64                 sel_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  // No grant is issued while reset is held, so pending requests survive it.
  assign ready       = reset ? '0 : gnt;
  assign req_ready_o = ready;
  assign any_gnt     = |ready;

  // One-hot grant to index, and selection of the winning address/data.
  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i]) begin
        gnt_idx  = PTR_W'(i);
        sel_addr = req_addr_i[i];
        sel_data = req_data_i[i];
      end
    end
  end

  // Next-state: pointer moves past the winner, address 0 writes are dropped,
  // and any valid requester left waiting counts as contention.
  always_comb begin
    rr_ptr_d         = rr_ptr_q;
    wvalid_d         = 1'b0;
    contention_cnt_d = contention_cnt_q;
    if (any_gnt) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      wvalid_d = (sel_addr != '0);
    end
    if (|(req_valid_i & ~ready)) begin
      contention_cnt_d = sat_inc(contention_cnt_q);
    end
  end

  // State and output registers; wa/wd only load on an accepted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q         <= '0;
      wvalid_q         <= 1'b0;
      wa_q             <= '0;
      wd_q             <= '0;
      contention_cnt_q <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      wvalid_q         <= wvalid_d;
      contention_cnt_q <= contention_cnt_d;
      if (any_gnt) begin
        wa_q <= sel_addr;
        wd_q <= sel_data;
      end
    end
  end

  assign wa_o             = wa_q;
  assign wvalid_o         = wvalid_q;
  assign wd_o             = wd_q;
  assign contention_cnt_o = contention_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_regfile_wb_arbiter                                       |
// | Brief  : Self-checking bench for regfile_wb_arbiter: reference model |
// |          compared every cycle plus directed literal expectations.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int N = WB_REQ_PORTS;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  creg_addr_t   req_addr [N];
  u64           req_data [N];
  logic [N-1:0] req_ready;
  creg_addr_t   wa;
  logic         wvalid;
  u64           wd;
  logic [31:0]  contention_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid),
    .req_addr_i       (req_addr),
    .req_data_i       (req_data),
    .req_ready_o      (req_ready),
    .wa_o             (wa),
    .wvalid_o         (wvalid),
    .wd_o             (wd),
    .contention_cnt_o (contention_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  int          m_ptr  = 0;
  logic        m_wv   = 1'b0;
  creg_addr_t  m_wa   = '0;
  u64          m_wd   = '0;
  logic [31:0] m_cnt  = '0;
  bit          m_live = 1'b0;

  // Round-robin rule: first valid requester at or after p, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int popcnt(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  // Model advances on each rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    int g;
    if (reset) begin
      m_ptr  <= 0;
      m_wv   <= 1'b0;
      m_wa   <= '0;
      m_wd   <= '0;
      m_cnt  <= '0;
      m_live <= 1'b1;
    end else begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        m_wa  <= req_addr[g];
        m_wd  <= req_data[g];
        m_wv  <= (req_addr[g] != 0);
        m_ptr <= (g + 1) % N;
      end else begin
        m_wv <= 1'b0;
      end
      if (popcnt(req_valid) > ((g >= 0) ? 1 : 0))
        m_cnt <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
    end
  end

  // Compare every cycle, between edges, once the model has seen reset.
  initial begin
    logic [N-1:0] exp_ready;
    int g;
    forever begin
      @(negedge clk);
      #2;
      if (m_live) begin
        g = pick(req_valid, m_ptr);
        exp_ready = '0;
        if (!reset && g >= 0) exp_ready[g] = 1'b1;
        chk("m_ready",  64'(req_ready),      64'(exp_ready));
        chk("m_wvalid", 64'(wvalid),         64'(m_wv));
        chk("m_wa",     64'(wa),             64'(m_wa));
        chk("m_wd",     wd,                  m_wd);
        chk("m_cnt",    64'(contention_cnt), 64'(m_cnt));
      end
    end
  end

  // Advance to the next cycle with new request vector; settle past the checker.
  task automatic step(input logic [N-1:0] v);
    @(negedge clk);
    req_valid = v;
    #3;
  endtask

  initial begin
    logic [N-1:0] seq [6];
    logic [N-1:0] pat [8];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    pat = '{3'b110, 3'b011, 3'b111, 3'b100, 3'b000, 3'b110, 3'b111, 3'b010};
    req_addr = '{5'd1, 5'd2, 5'd3};
    req_data = '{64'hA0, 64'hB1, 64'hC2};

    // Reset with all requesters pending: nothing granted, outputs cleared.
    reset = 1'b1;
    req_valid = 3'b111;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("rst_ready",  64'(req_ready), 64'h0);
    chk("rst_wvalid", 64'(wvalid), 64'h0);
    chk("rst_wa",     64'(wa), 64'h0);
    chk("rst_wd",     wd, 64'h0);
    chk("rst_cnt",    64'(contention_cnt), 64'h0);

    // Continuous requests from all three: 0,1,2,0,1,2 with contention each cycle.
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("rr_ready0", 64'(req_ready), 64'(seq[0]));
    for (int i = 1; i < 6; i++) begin
      step(3'b111);
      chk("rr_ready", 64'(req_ready), 64'(seq[i]));
    end
    step(3'b111);
    chk("rr_cnt6",   64'(contention_cnt), 64'd6);
    chk("rr_wa",     64'(wa), 64'd3);
    chk("rr_wvalid", 64'(wvalid), 64'd1);

    // Reset while a write is on the outputs.
    reset = 1'b1;
    step(3'b111);
    chk("mrst_wvalid", 64'(wvalid), 64'h0);
    chk("mrst_cnt",    64'(contention_cnt), 64'h0);
    chk("mrst_ready",  64'(req_ready), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("mrst_first", 64'(req_ready), 64'b001);
    step(3'b000);

    // Single requester: same-cycle grant, write one cycle later.
    @(negedge clk);
    req_addr[0] = 5'd5;
    req_data[0] = 64'hDEAD;
    req_valid = 3'b001;
    #3;
    chk("single_ready", 64'(req_ready), 64'b001);
    step(3'b000);
    chk("single_wa",     64'(wa), 64'd5);
    chk("single_wd",     wd, 64'hDEAD);
    chk("single_wvalid", 64'(wvalid), 64'd1);

    // Address zero is consumed without a write; pointer moves to 2.
    @(negedge clk);
    req_addr[1] = 5'd0;
    req_data[1] = 64'h1234;
    req_valid = 3'b010;
    #3;
    chk("a0_ready", 64'(req_ready), 64'b010);
    step(3'b111);
    chk("a0_wvalid", 64'(wvalid), 64'd0);
    chk("a0_ptr2",   64'(req_ready), 64'b100);

    // Pointer skipping: ptr=1 with 101 grants 2, then 0.
    step(3'b001);
    chk("skip_pre", 64'(req_ready), 64'b001);
    step(3'b101);
    chk("skip_g2", 64'(req_ready), 64'b100);
    step(3'b101);
    chk("skip_g0", 64'(req_ready), 64'b001);

    // Assorted patterns with fresh data; the model compare covers these.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        req_addr[r] = creg_addr_t'((i * 3 + r * 7) % 32);
        req_data[r] = 64'h1111_0000_0000_0000 * (i + 1) + 64'(r);
      end
      req_valid = pat[i];
    end
    step(3'b000);

    // Saturation: preload near the ceiling, then keep two requesters valid.
    @(negedge clk);
    req_valid = 3'b011;
    force dut.contention_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.contention_cnt_q;
    for (int i = 0; i < 3; i++) begin
      step(3'b011);
      chk("sat_cnt", 64'(contention_cnt), 64'hFFFF_FFFF);
    end
    step(3'b000);
    step(3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
